move_sequencer: RTL and testbench

- Sequential successor to the combinational test-position selector.
- Latches movement requests (gravity tick, left, right, rotate, soft-down, hard drop) and serialises them by priority.
- Drives one candidate pose at a time to the collision checker over a valid/done handshake. Commits accepted poses into the current-piece registers.
- Adds what the old selector lacked: a request queue, parametrised geometry and rotation count, rotation wall-kicks, hard-drop iteration and lock detection.

---
 rtl/move_sequencer.sv | 271 +++++++++++++++++++++++++++
 tb/tb_move_sequencer.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/move_sequencer.sv
// Movement request sequencer: latches piece-move requests, serialises them by priority and
// proves each candidate pose against an external collision checker before committing it.
module move_sequencer #(
    parameter int X_W       = 4,
    parameter int Y_W       = 5,
    parameter int ROT_N     = 4,
    parameter int MAX_KICK  = 2,
    parameter int SPAWN_X   = 4,
    parameter int SPAWN_Y   = 0,
    parameter int MODE_BITS = 2,
    parameter logic [MODE_BITS-1:0] MODE_PLAY = MODE_BITS'(1),
    parameter logic [MODE_BITS-1:0] MODE_DROP = MODE_BITS'(2),
    localparam int ROT_W    = $clog2(ROT_N)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [MODE_BITS-1:0] mode,
    input  logic                 spawn_en,
    input  logic                 gravity_tick,
    input  logic                 btn_left_en,
    input  logic                 btn_right_en,
    input  logic                 btn_rotate_en,
    input  logic                 btn_down_en,
    output logic                 test_valid,
    output logic [X_W-1:0]       test_x,
    output logic [Y_W-1:0]       test_y,
    output logic [ROT_W-1:0]     test_rot,
    input  logic                 chk_done,
    input  logic                 chk_collide,
    output logic [X_W-1:0]       cur_x,
    output logic [Y_W-1:0]       cur_y,
    output logic [ROT_W-1:0]     cur_rot,
    output logic                 lock_out,
    output logic                 busy
);

    localparam int KI_W    = (MAX_KICK > 1) ? $clog2(2 * MAX_KICK) : 1;
    localparam int REQ_G   = 4;
    localparam int REQ_L   = 3;
    localparam int REQ_R   = 2;
    localparam int REQ_ROT = 1;
    localparam int REQ_D   = 0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_TEST   = 2'd1,
        ST_KICK   = 2'd2,
        ST_LOCKED = 2'd3
    } state_t;

    state_t            state_r;
    logic [4:0]        pend_r;
    logic [4:0]        req_r;
    logic [KI_W-1:0]   kick_idx_r;
    logic              kick_wait_r;
    logic              test_valid_r;
    logic [X_W-1:0]    test_x_r;
    logic [Y_W-1:0]    test_y_r;
    logic [ROT_W-1:0]  test_rot_r;
    logic [X_W-1:0]    cur_x_r;
    logic [Y_W-1:0]    cur_y_r;
    logic [ROT_W-1:0]  cur_rot_r;
    logic              lock_r;
    logic              busy_r;

    logic              mode_play_s;
    logic              mode_drop_s;
    logic [4:0]        set_s;
    logic [4:0]        eff_s;
    logic [4:0]        sel_s;
    logic [X_W-1:0]    cand_x_s;
    logic [Y_W-1:0]    cand_y_s;
    logic [ROT_W-1:0]  cand_rot_s;
    logic [X_W-1:0]    kick_x_s;
    logic              kick_last_s;

    function automatic logic [ROT_W-1:0] rot_next(input logic [ROT_W-1:0] r);
        if (r == ROT_W'(ROT_N - 1)) begin
            rot_next = {ROT_W{1'b0}};
        end else begin
            rot_next = r + ROT_W'(1);
        end
    endfunction

    // Kick order is +1, -1, +2, -2 ...: bit 0 of the index picks the sign.
    function automatic logic [X_W-1:0] kick_pos(input logic [X_W-1:0] x, input logic [KI_W-1:0] idx);
        logic [X_W-1:0] mag;
        mag = X_W'(32'(idx >> 1) + 32'd1);
        if (idx[0]) begin
            kick_pos = x - mag;
        end else begin
            kick_pos = x + mag;
        end
    endfunction

    // Request masking by mode and the effective pending set used for launch selection.
    always_comb begin
        mode_play_s = (mode == MODE_PLAY);
        mode_drop_s = (mode == MODE_DROP);
        set_s = {gravity_tick,
                 btn_left_en   & ~mode_drop_s,
                 btn_right_en  & ~mode_drop_s,
                 btn_rotate_en & ~mode_drop_s,
                 btn_down_en};
        if (mode_play_s) begin
            eff_s = pend_r;
        end else if (mode_drop_s) begin
            eff_s = {pend_r[REQ_G], 3'b000, 1'b1};
        end else begin
            eff_s = 5'b00000;
        end
    end

    // Fixed-priority pick: G > L > R > ROT > D.
    always_comb begin
        if (eff_s[REQ_G]) begin
            sel_s = 5'b10000;
        end else if (eff_s[REQ_L]) begin
            sel_s = 5'b01000;
        end else if (eff_s[REQ_R]) begin
            sel_s = 5'b00100;
        end else if (eff_s[REQ_ROT]) begin
            sel_s = 5'b00010;
        end else if (eff_s[REQ_D]) begin
            sel_s = 5'b00001;
        end else begin
            sel_s = 5'b00000;
        end
    end

    // Candidate pose for the selected request; coordinates wrap so the checker rejects them.
    always_comb begin
        cand_x_s   = cur_x_r;
        cand_y_s   = cur_y_r;
        cand_rot_s = cur_rot_r;
        case (sel_s)
            5'b10000, 5'b00001: cand_y_s   = cur_y_r + Y_W'(1);
            5'b01000:           cand_x_s   = cur_x_r - X_W'(1);
            5'b00100:           cand_x_s   = cur_x_r + X_W'(1);
            5'b00010:           cand_rot_s = rot_next(cur_rot_r);
            default: begin
                cand_x_s   = cur_x_r;
                cand_y_s   = cur_y_r;
                cand_rot_s = cur_rot_r;
            end
        endcase
        kick_x_s    = kick_pos(cur_x_r, kick_idx_r);
        kick_last_s = (kick_idx_r == KI_W'(2 * MAX_KICK - 1));
    end

    // Sequencer FSM with pending-request vector and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r      <= ST_LOCKED;
            busy_r       <= 1'b1;
            pend_r       <= 5'b00000;
            req_r        <= 5'b00000;
            kick_idx_r   <= {KI_W{1'b0}};
            kick_wait_r  <= 1'b0;
            test_valid_r <= 1'b0;
            test_x_r     <= {X_W{1'b0}};
            test_y_r     <= {Y_W{1'b0}};
            test_rot_r   <= {ROT_W{1'b0}};
            cur_x_r      <= {X_W{1'b0}};
            cur_y_r      <= {Y_W{1'b0}};
            cur_rot_r    <= {ROT_W{1'b0}};
            lock_r       <= 1'b0;
        end else begin
            lock_r <= 1'b0;
            if (spawn_en) begin
                cur_x_r      <= X_W'(SPAWN_X);
                cur_y_r      <= Y_W'(SPAWN_Y);
                cur_rot_r    <= {ROT_W{1'b0}};
                pend_r       <= 5'b00000;
                test_valid_r <= 1'b0;
                kick_wait_r  <= 1'b0;
                state_r      <= ST_IDLE;
                busy_r       <= 1'b0;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        if (|sel_s) begin
                            test_x_r     <= cand_x_s;
                            test_y_r     <= cand_y_s;
                            test_rot_r   <= cand_rot_s;
                            test_valid_r <= 1'b1;
                            req_r        <= sel_s;
                            pend_r       <= (pend_r & ~sel_s) | set_s;
                            state_r      <= ST_TEST;
                            busy_r       <= 1'b1;
                        end else begin
                            pend_r <= pend_r | set_s;
                        end
                    end
                    ST_TEST: begin
                        pend_r <= pend_r | set_s;
                        if (chk_done && !chk_collide) begin
                            cur_x_r      <= test_x_r;
                            cur_y_r      <= test_y_r;
                            cur_rot_r    <= test_rot_r;
                            test_valid_r <= 1'b0;
                            state_r      <= ST_IDLE;
                            busy_r       <= 1'b0;
                        end else if (chk_done) begin
                            test_valid_r <= 1'b0;
                            if (req_r[REQ_G] || req_r[REQ_D]) begin
                                lock_r  <= 1'b1;
                                pend_r  <= 5'b00000;
                                state_r <= ST_LOCKED;
                            end else if (req_r[REQ_ROT] && (MAX_KICK > 0)) begin
                                kick_idx_r  <= {KI_W{1'b0}};
                                kick_wait_r <= 1'b0;
                                state_r     <= ST_KICK;
                            end else begin
                                state_r <= ST_IDLE;
                                busy_r  <= 1'b0;
                            end
                        end
                    end
                    ST_KICK: begin
                        pend_r <= pend_r | set_s;
                        if (!kick_wait_r) begin
                            test_x_r     <= kick_x_s;
                            test_y_r     <= cur_y_r;
                            test_valid_r <= 1'b1;
                            kick_wait_r  <= 1'b1;
                        end else if (chk_done && !chk_collide) begin
                            cur_x_r      <= test_x_r;
                            cur_y_r      <= test_y_r;
                            cur_rot_r    <= test_rot_r;
                            test_valid_r <= 1'b0;
                            kick_wait_r  <= 1'b0;
                            state_r      <= ST_IDLE;
                            busy_r       <= 1'b0;
                        end else if (chk_done) begin
                            test_valid_r <= 1'b0;
                            kick_wait_r  <= 1'b0;
                            if (kick_last_s) begin
                                state_r <= ST_IDLE;
                                busy_r  <= 1'b0;
                            end else begin
                                kick_idx_r <= kick_idx_r + KI_W'(1);
                            end
                        end
                    end
                    ST_LOCKED: begin
                        test_valid_r <= 1'b0;
                        pend_r       <= 5'b00000;
                    end
                    default: begin
                        test_valid_r <= 1'b0;
                        pend_r       <= 5'b00000;
                        state_r      <= ST_LOCKED;
                        busy_r       <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign test_valid = test_valid_r;
    assign test_x     = test_x_r;
    assign test_y     = test_y_r;
    assign test_rot   = test_rot_r;
    assign cur_x      = cur_x_r;
    assign cur_y      = cur_y_r;
    assign cur_rot    = cur_rot_r;
    assign lock_out   = lock_r;
    assign busy       = busy_r;

endmodule

// File: tb/tb_move_sequencer.sv
// Bench for move_sequencer: directed scenarios followed by random request bursts checked
// against a pose-level reference model, with the bench acting as the collision checker.
module tb_move_sequencer;

    localparam logic [1:0] MODE_PLAY = 2'd1;
    localparam logic [1:0] MODE_DROP = 2'd2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] mode = MODE_PLAY;
    logic       spawn_en = 1'b0;
    logic       gravity_tick = 1'b0;
    logic       btn_left_en = 1'b0;
    logic       btn_right_en = 1'b0;
    logic       btn_rotate_en = 1'b0;
    logic       btn_down_en = 1'b0;
    logic       chk_done = 1'b0;
    logic       chk_collide = 1'b0;
    logic       test_valid;
    logic [3:0] test_x;
    logic [4:0] test_y;
    logic [1:0] test_rot;
    logic [3:0] cur_x;
    logic [4:0] cur_y;
    logic [1:0] cur_rot;
    logic       lock_out;
    logic       busy;

    always #5 clk = ~clk;

    move_sequencer dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .spawn_en(spawn_en),
        .gravity_tick(gravity_tick), .btn_left_en(btn_left_en), .btn_right_en(btn_right_en),
        .btn_rotate_en(btn_rotate_en), .btn_down_en(btn_down_en),
        .test_valid(test_valid), .test_x(test_x), .test_y(test_y), .test_rot(test_rot),
        .chk_done(chk_done), .chk_collide(chk_collide),
        .cur_x(cur_x), .cur_y(cur_y), .cur_rot(cur_rot), .lock_out(lock_out), .busy(busy)
    );

    int checks = 0;
    int errors = 0;
    int lock_cnt = 0;
    bit blk [0:15][0:31];
    int mx, my, mr;
    bit mlocked;
    int qx[$];
    int qy[$];
    int qr[$];

    task automatic step();
        @(posedge clk);
        #1;
        if (lock_out === 1'b1) lock_cnt++;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic chk_cur(input string tag, input int x, input int y, input int r);
        chk({tag, ".cur_x"}, 32'(cur_x), x);
        chk({tag, ".cur_y"}, 32'(cur_y), y);
        chk({tag, ".cur_rot"}, 32'(cur_rot), r);
    endtask

    // m = {spawn, gravity, left, right, rotate, down}
    task automatic pulse(input bit [5:0] m);
        {spawn_en, gravity_tick, btn_left_en, btn_right_en, btn_rotate_en, btn_down_en} = m;
        step();
        {spawn_en, gravity_tick, btn_left_en, btn_right_en, btn_rotate_en, btn_down_en} = 6'b000000;
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (test_valid !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        chk({tag, ".launch"}, 32'(test_valid), 32'd1);
    endtask

    task automatic probe(input int ex, input int ey, input int er, input bit collide,
                         input int lat, input string tag);
        wait_valid(tag);
        chk({tag, ".test_x"}, 32'(test_x), ex);
        chk({tag, ".test_y"}, 32'(test_y), ey);
        chk({tag, ".test_rot"}, 32'(test_rot), er);
        repeat (lat) step();
        if (lat > 0) chk({tag, ".hold_x"}, 32'(test_x), ex);
        chk_done = 1'b1;
        chk_collide = collide;
        step();
        chk_done = 1'b0;
        chk_collide = 1'b0;
        chk({tag, ".valid_drop"}, 32'(test_valid), 32'd0);
    endtask

    // Field of width 10 and height 20; odd rotations occupy one extra column to the right.
    function automatic bit collides(input int x, input int y, input int r);
        if (x >= 10 || y >= 20) return 1'b1;
        if (blk[x][y]) return 1'b1;
        if (r % 2 == 1) begin
            if (x + 1 >= 10) return 1'b1;
            if (blk[x + 1][y]) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic regen();
        for (int x = 0; x < 16; x++)
            for (int y = 0; y < 32; y++)
                blk[x][y] = ($urandom_range(0, 5) == 0);
    endtask

    task automatic push(input int x, input int y, input int r);
        qx.push_back(x);
        qy.push_back(y);
        qr.push_back(r);
    endtask

    // Reference: walk requests in priority order and list every pose the checker should see.
    task automatic model(input bit [4:0] m);
        int nx, ny, nr, off, kx;
        for (int k = 4; k >= 0; k--) begin
            if (m[k] && !mlocked) begin
                nx = mx; ny = my; nr = mr;
                if (k == 4 || k == 0) ny = (my + 1) % 32;
                else if (k == 3) nx = (mx + 15) % 16;
                else if (k == 2) nx = (mx + 1) % 16;
                else nr = (mr + 1) % 4;
                push(nx, ny, nr);
                if (!collides(nx, ny, nr)) begin
                    mx = nx; my = ny; mr = nr;
                end else if (k == 4 || k == 0) begin
                    mlocked = 1'b1;
                end else if (k == 1) begin
                    for (int i = 0; i < 4; i++) begin
                        off = (i / 2 + 1) * ((i % 2 == 1) ? -1 : 1);
                        kx = (mx + off + 16) % 16;
                        push(kx, my, nr);
                        if (!collides(kx, my, nr)) begin
                            mx = kx; mr = nr;
                            break;
                        end
                    end
                end
            end
        end
    endtask

    initial begin
        bit [4:0] m;
        int lc;
        int lat;

        // Reset and latency
        step();
        step();
        chk_cur("reset", 0, 0, 0);
        chk("reset.test_valid", 32'(test_valid), 32'd0);
        chk("reset.test_x", 32'(test_x), 32'd0);
        chk("reset.lock_out", 32'(lock_out), 32'd0);
        chk("reset.busy", 32'(busy), 32'd1);
        rst_n = 1'b1;
        pulse(6'b000100);
        step();
        step();
        chk("locked.drop", 32'(test_valid), 32'd0);
        pulse(6'b100000);
        chk_cur("spawn", 4, 0, 0);
        chk("spawn.busy", 32'(busy), 32'd0);
        pulse(6'b000100);
        chk("lat.first", 32'(test_valid), 32'd0);
        step();
        probe(5, 0, 0, 1'b0, 1, "right");
        chk_cur("right", 5, 0, 0);
        chk("right.busy", 32'(busy), 32'd0);

        // Unknown mode holds requests
        mode = 2'd0;
        pulse(6'b000100);
        repeat (4) step();
        chk("badmode.hold", 32'(test_valid), 32'd0);
        mode = MODE_PLAY;
        probe(6, 0, 0, 1'b0, 1, "resume");

        // Walk to x=0, then left wraps to 15 and collides
        for (int i = 6; i > 0; i--) begin
            pulse(6'b001000);
            probe(i - 1, 0, 0, 1'b0, 0, "walk");
        end
        pulse(6'b001000);
        probe(15, 0, 0, 1'b1, 1, "wrap");
        step();
        chk_cur("wrap", 0, 0, 0);
        chk("wrap.no_lock", 32'(lock_cnt), 32'd0);
        chk("wrap.busy", 32'(busy), 32'd0);

        // Gravity beats left when both arrive together
        pulse(6'b100000);
        for (int i = 0; i < 3; i++) begin
            pulse(6'b010000);
            probe(4, i + 1, 0, 1'b0, 0, "fall");
        end
        pulse(6'b011000);
        probe(4, 4, 0, 1'b0, 1, "g_first");
        probe(3, 4, 0, 1'b0, 1, "l_second");
        chk_cur("gl", 3, 4, 0);

        // Rotation with wall kicks
        pulse(6'b100000);
        for (int i = 0; i < 3; i++) begin
            pulse(6'b000010);
            probe(4, 0, i + 1, 1'b0, 0, "spin");
        end
        for (int i = 0; i < 7; i++) begin
            pulse(6'b010000);
            probe(4, i + 1, 3, 1'b0, 0, "sink");
        end
        pulse(6'b000010);
        probe(4, 7, 0, 1'b1, 1, "rot0");
        probe(5, 7, 0, 1'b1, 0, "kick_p1");
        probe(3, 7, 0, 1'b0, 2, "kick_m1");
        chk_cur("kick", 3, 7, 0);
        chk("kick.busy", 32'(busy), 32'd0);
        pulse(6'b000010);
        probe(3, 7, 1, 1'b1, 0, "nk0");
        probe(4, 7, 1, 1'b1, 0, "nk_p1");
        probe(2, 7, 1, 1'b1, 0, "nk_m1");
        probe(5, 7, 1, 1'b1, 0, "nk_p2");
        probe(1, 7, 1, 1'b1, 0, "nk_m2");
        step();
        chk_cur("nokick", 3, 7, 0);
        chk("nokick.busy", 32'(busy), 32'd0);

        // Drop mode until landing
        pulse(6'b100000);
        for (int i = 0; i < 10; i++) begin
            pulse(6'b010000);
            probe(4, i + 1, 0, 1'b0, 0, "pre");
        end
        lc = lock_cnt;
        mode = MODE_DROP;
        for (int y = 11; y <= 15; y++) begin
            if (y == 13) pulse(6'b001110);
            probe(4, y, 0, 1'b0, 0, "drop");
        end
        probe(4, 16, 0, 1'b1, 1, "land");
        chk("land.lock", 32'(lock_cnt - lc), 32'd1);
        chk("land.busy", 32'(busy), 32'd1);
        chk_cur("land", 4, 15, 0);
        mode = MODE_PLAY;
        pulse(6'b001000);
        pulse(6'b010000);
        repeat (3) step();
        chk("locked.idle", 32'(test_valid), 32'd0);
        chk("land.one_pulse", 32'(lock_cnt - lc), 32'd1);
        chk_cur("locked", 4, 15, 0);
        pulse(6'b100000);
        chk_cur("respawn", 4, 0, 0);
        repeat (4) step();
        chk("respawn.quiet", 32'(test_valid), 32'd0);

        // Spawn aborts an outstanding test
        pulse(6'b000100);
        probe(5, 0, 0, 1'b0, 0, "pre_abort");
        pulse(6'b000100);
        wait_valid("abort");
        chk("abort.test_x", 32'(test_x), 32'd6);
        pulse(6'b001000);
        pulse(6'b100000);
        chk("abort.valid", 32'(test_valid), 32'd0);
        chk_cur("abort", 4, 0, 0);
        chk("abort.busy", 32'(busy), 32'd0);
        chk_done = 1'b1;
        step();
        chk_done = 1'b0;
        chk_cur("late_done", 4, 0, 0);
        repeat (4) step();
        chk("abort.pend_clear", 32'(test_valid), 32'd0);

        // Random request bursts against the reference model
        regen();
        pulse(6'b100000);
        mx = 4; my = 0; mr = 0; mlocked = 1'b0;
        for (int it = 0; it < 80; it++) begin
            m = 5'($urandom_range(1, 31));
            lc = lock_cnt;
            model(m);
            pulse({1'b0, m});
            while (qx.size() > 0) begin
                lat = $urandom_range(0, 2);
                wait_valid("rnd");
                chk("rnd.test_x", 32'(test_x), qx.pop_front());
                chk("rnd.test_y", 32'(test_y), qy.pop_front());
                chk("rnd.test_rot", 32'(test_rot), qr.pop_front());
                repeat (lat) step();
                chk_done = 1'b1;
                chk_collide = collides(int'(test_x), int'(test_y), int'(test_rot));
                step();
                chk_done = 1'b0;
                chk_collide = 1'b0;
            end
            step();
            step();
            chk("rnd.settled", 32'(test_valid), 32'd0);
            chk_cur("rnd", mx, my, mr);
            chk("rnd.busy", 32'(busy), 32'(mlocked));
            chk("rnd.lock", 32'(lock_cnt - lc), 32'(mlocked));
            if (mlocked) begin
                regen();
                pulse(6'b100000);
                mx = 4; my = 0; mr = 0; mlocked = 1'b0;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
